rf_wb_unit: RTL and testbench



---
 rtl/rv_wb_pkg.sv | 45 ++++
 rtl/wb_load_queue.sv | 53 +++++
 rtl/rf_wb_unit.sv | 121 ++++++++++++
 tb/tb_rf_wb_unit.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/rv_wb_pkg.sv
// rtl/rv_wb_pkg.sv - shared encodings, load-queue entry and load lane extraction
package rv_wb_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  localparam logic [2:0] WSTRB_WORD = 3'b100;
  localparam logic [2:0] WSTRB_HALF = 3'b010;
  localparam logic [2:0] WSTRB_BYTE = 3'b001;

  // RV32I always has 32 architectural registers, so the queue stores a 5-bit rd.
  localparam int RD_W = 5;

  typedef struct packed {
    logic [RD_W-1:0] rd;
    logic [1:0]      size;
    logic            uns;
    logic [1:0]      offset;
  } lq_entry_t;

  function automatic logic [31:0] lq_extract(input logic [31:0] data,
                                             input logic [1:0]  size,
                                             input logic [1:0]  offset,
                                             input logic        uns);
    logic [7:0]  b;
    logic [15:0] h;
    b = data[{offset, 3'b000} +: 8];
    h = data[{offset[1], 4'b0000} +: 16];
    case (size)
      SZ_BYTE: return {{24{b[7] & ~uns}}, b};
      SZ_HALF: return {{16{h[15] & ~uns}}, h};
      default: return data;
    endcase
  endfunction

  function automatic logic [2:0] lq_strobe(input logic [1:0] size);
    case (size)
      SZ_BYTE: return WSTRB_BYTE;
      SZ_HALF: return WSTRB_HALF;
      default: return WSTRB_WORD;
    endcase
  endfunction

endpackage

// File: rtl/wb_load_queue.sv
// rtl/wb_load_queue.sv - synchronous FIFO of outstanding load metadata
module wb_load_queue
  import rv_wb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      push,
  input  lq_entry_t wdata,
  input  logic      pop,
  output lq_entry_t rdata,
  output logic      full,
  output logic      empty
);

  localparam int PW = $clog2(DEPTH);

  lq_entry_t      mem [DEPTH];
  logic [PW-1:0]  wr_ptr;
  logic [PW-1:0]  rd_ptr;
  logic [PW:0]    count;
  logic           do_push;
  logic           do_pop;

  assign full    = (count == (PW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  // A full queue still accepts a push when the head leaves on the same edge.
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (PW+1)'(1);
        2'b01:   count <= count - (PW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/rf_wb_unit.sv
// rtl/rf_wb_unit.sv - register-file writeback arbiter for ALU results and load responses
module rf_wb_unit
  import rv_wb_pkg::*;
#(
  parameter  int DEPTH    = 32,
  parameter  int WIDTH    = 32,
  parameter  int LQ_DEPTH = 4,
  localparam int ADDR_W   = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              alu_valid,
  output logic              alu_ready,
  input  logic [ADDR_W-1:0] alu_rd,
  input  logic [WIDTH-1:0]  alu_data,
  input  logic              ld_valid,
  output logic              ld_ready,
  input  logic [ADDR_W-1:0] ld_rd,
  input  logic [1:0]        ld_size,
  input  logic              ld_unsigned,
  input  logic [1:0]        ld_offset,
  input  logic              mem_rvalid,
  input  logic [WIDTH-1:0]  mem_rdata,
  output logic              rf_we,
  output logic [ADDR_W-1:0] rf_waddr,
  output logic [WIDTH-1:0]  rf_wdata,
  output logic [2:0]        rf_wstrobe,
  output logic [DEPTH-1:0]  busy,
  output logic              err
);

  lq_entry_t         lq_wentry;
  lq_entry_t         lq_rentry;
  logic              lq_push;
  logic              lq_pop;
  logic              lq_full;
  logic              lq_empty;
  logic              alu_fire;
  logic              skid_valid;
  logic [ADDR_W-1:0] skid_rd;
  logic [WIDTH-1:0]  skid_data;
  logic [ADDR_W-1:0] pop_rd;
  logic [DEPTH-1:0]  busy_nxt;

  assign alu_ready = !rst && !skid_valid;
  assign alu_fire  = alu_valid && alu_ready;
  assign lq_pop    = !rst && mem_rvalid && !lq_empty;
  assign ld_ready  = !rst && (!lq_full || lq_pop) && !busy[ld_rd];
  assign lq_push   = ld_valid && ld_ready;
  assign pop_rd    = ADDR_W'(lq_rentry.rd);

  always_comb begin
    lq_wentry        = '0;
    lq_wentry.rd     = RD_W'(ld_rd);
    lq_wentry.size   = ld_size;
    lq_wentry.uns    = ld_unsigned;
    lq_wentry.offset = ld_offset;
  end

  wb_load_queue #(.DEPTH(LQ_DEPTH)) u_lq (
    .clk   (clk),
    .rst   (rst),
    .push  (lq_push),
    .wdata (lq_wentry),
    .pop   (lq_pop),
    .rdata (lq_rentry),
    .full  (lq_full),
    .empty (lq_empty)
  );

  always_comb begin
    busy_nxt = busy;
    if (lq_pop) busy_nxt[pop_rd] = 1'b0;
    if (lq_push && ld_rd != '0) busy_nxt[ld_rd] = 1'b1;
  end

  // Load responses own the port; a displaced ALU result waits in the skid buffer.
  always_ff @(posedge clk) begin
    if (rst) begin
      rf_we      <= 1'b0;
      rf_waddr   <= '0;
      rf_wdata   <= '0;
      rf_wstrobe <= WSTRB_WORD;
      busy       <= '0;
      err        <= 1'b0;
      skid_valid <= 1'b0;
      skid_rd    <= '0;
      skid_data  <= '0;
    end else begin
      busy <= busy_nxt;
      if (mem_rvalid && lq_empty) err <= 1'b1;

      if (lq_pop) begin
        rf_we      <= (pop_rd != '0);
        rf_waddr   <= pop_rd;
        rf_wdata   <= lq_extract(mem_rdata, lq_rentry.size, lq_rentry.offset, lq_rentry.uns);
        rf_wstrobe <= lq_strobe(lq_rentry.size);
      end else if (skid_valid && !mem_rvalid) begin
        rf_we      <= (skid_rd != '0);
        rf_waddr   <= skid_rd;
        rf_wdata   <= skid_data;
        rf_wstrobe <= WSTRB_WORD;
        skid_valid <= 1'b0;
      end else if (alu_fire && !mem_rvalid) begin
        rf_we      <= (alu_rd != '0);
        rf_waddr   <= alu_rd;
        rf_wdata   <= alu_data;
        rf_wstrobe <= WSTRB_WORD;
      end else begin
        rf_we      <= 1'b0;
      end

      if (alu_fire && mem_rvalid) begin
        skid_valid <= 1'b1;
        skid_rd    <= alu_rd;
        skid_data  <= alu_data;
      end
    end
  end

endmodule

// File: tb/tb_rf_wb_unit.sv
// tb/tb_rf_wb_unit.sv - randomized self-checking bench for rf_wb_unit against a queue-based model
module tb_rf_wb_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        alu_valid, alu_ready;
  logic [4:0]  alu_rd;
  logic [31:0] alu_data;
  logic        ld_valid, ld_ready;
  logic [4:0]  ld_rd;
  logic [1:0]  ld_size;
  logic        ld_unsigned;
  logic [1:0]  ld_offset;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic [2:0]  rf_wstrobe;
  logic [31:0] busy;
  logic        err;

  always #5 clk = ~clk;

  rf_wb_unit dut (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_rd(ld_rd), .ld_size(ld_size),
    .ld_unsigned(ld_unsigned), .ld_offset(ld_offset),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .rf_wstrobe(rf_wstrobe),
    .busy(busy), .err(err)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  typedef struct {
    int rd;
    int size;
    bit uns;
    int off;
  } ld_t;

  ld_t         m_lq[$];
  int          m_alu_rd[$];
  logic [31:0] m_alu_d[$];
  bit   [31:0] m_busy;
  bit          m_err;
  logic        obs_ar, obs_lr;

  function automatic logic [31:0] ref_ld(logic [31:0] d, int size, bit uns, int off);
    logic [31:0] v;
    if (size == 0) begin
      v = (d >> (8 * off)) & 32'hFF;
      if (!uns && v[7]) v = v | 32'hFFFF_FF00;
    end else if (size == 1) begin
      v = (d >> (16 * (off / 2))) & 32'hFFFF;
      if (!uns && v[15]) v = v | 32'hFFFF_0000;
    end else begin
      v = d;
    end
    return v;
  endfunction

  task automatic idle();
    rst = 1'b0; alu_valid = 1'b0; ld_valid = 1'b0; mem_rvalid = 1'b0;
    alu_rd = '0; alu_data = '0; ld_rd = '0; ld_size = '0; ld_unsigned = 1'b0;
    ld_offset = '0; mem_rdata = '0;
  endtask

  // One clock: check handshakes against the model, advance the model, then check the port.
  task automatic cycle();
    bit          ew, exp_ar, exp_lr;
    int          ea;
    logic [31:0] ed;
    logic [2:0]  es;
    ld_t         e;
    ew = 0; ea = 0; ed = '0; es = 3'b100;
    #1;
    exp_ar = !rst && (m_alu_rd.size() == 0);
    exp_lr = !rst && (m_lq.size() < 4 || (mem_rvalid && m_lq.size() > 0)) && !m_busy[ld_rd];
    obs_ar = alu_ready;
    obs_lr = ld_ready;
    check("alu_ready", {31'b0, alu_ready}, {31'b0, exp_ar});
    check("ld_ready", {31'b0, ld_ready}, {31'b0, exp_lr});
    if (rst) begin
      m_lq.delete(); m_alu_rd.delete(); m_alu_d.delete();
      m_busy = '0; m_err = 0;
    end else begin
      if (alu_valid && exp_ar) begin
        m_alu_rd.push_back(int'(alu_rd));
        m_alu_d.push_back(alu_data);
      end
      if (mem_rvalid) begin
        if (m_lq.size() > 0) begin
          e = m_lq.pop_front();
          ew = (e.rd != 0); ea = e.rd;
          ed = ref_ld(mem_rdata, e.size, e.uns, e.off);
          es = (e.size == 0) ? 3'b001 : (e.size == 1) ? 3'b010 : 3'b100;
          m_busy[e.rd] = 1'b0;
        end else begin
          m_err = 1;
        end
      end else if (m_alu_rd.size() > 0) begin
        ea = m_alu_rd.pop_front();
        ed = m_alu_d.pop_front();
        ew = (ea != 0);
      end
      if (ld_valid && exp_lr) begin
        e.rd = int'(ld_rd); e.size = int'(ld_size); e.uns = ld_unsigned; e.off = int'(ld_offset);
        m_lq.push_back(e);
        if (ld_rd != 0) m_busy[ld_rd] = 1'b1;
      end
    end
    @(posedge clk);
    #1;
    check("rf_we", {31'b0, rf_we}, {31'b0, ew});
    if (ew) begin
      check("rf_waddr", {27'b0, rf_waddr}, ea[31:0]);
      check("rf_wdata", rf_wdata, ed);
      check("rf_wstrobe", {29'b0, rf_wstrobe}, {29'b0, es});
    end
    if (rst) check("rst_wstrobe", {29'b0, rf_wstrobe}, 32'd4);
    check("busy", busy, m_busy);
    check("err", {31'b0, err}, {31'b0, m_err});
  endtask

  task automatic issue_ld(input int rd, input int size, input bit uns, input int off);
    idle();
    ld_valid = 1'b1; ld_rd = rd[4:0]; ld_size = size[1:0]; ld_unsigned = uns; ld_offset = off[1:0];
  endtask

  initial begin
    idle();
    rst = 1'b1;
    cycle();
    cycle();

    // ALU only
    idle(); alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'h1234_5678;
    cycle();
    check("alu_wdata", rf_wdata, 32'h1234_5678);
    check("alu_busy", busy, 32'h0);

    // signed byte load
    issue_ld(3, 0, 0, 2); cycle();
    check("lb_busy3", {31'b0, busy[3]}, 32'd1);
    idle(); mem_rvalid = 1'b1; mem_rdata = 32'h0080_0000; cycle();
    check("lb_wdata", rf_wdata, 32'hFFFF_FF80);
    check("lb_strobe", {29'b0, rf_wstrobe}, 32'd1);
    check("lb_busy3_clr", {31'b0, busy[3]}, 32'd0);

    // unsigned half load
    issue_ld(7, 1, 1, 2); cycle();
    idle(); mem_rvalid = 1'b1; mem_rdata = 32'hBEEF_0000; cycle();
    check("lhu_wdata", rf_wdata, 32'h0000_BEEF);

    // collision: load response wins, ALU result deferred one cycle
    issue_ld(2, 2, 0, 0); cycle();
    idle(); alu_valid = 1'b1; alu_rd = 5'd1; alu_data = 32'h11;
    mem_rvalid = 1'b1; mem_rdata = 32'hCAFE_F00D; cycle();
    check("col_first_addr", {27'b0, rf_waddr}, 32'd2);
    check("col_alu_ready", {31'b0, alu_ready}, 32'd0);
    idle(); cycle();
    check("col_second_addr", {27'b0, rf_waddr}, 32'd1);
    check("col_second_data", rf_wdata, 32'h11);

    // fill queue, then full / busy / push+pop-when-full
    for (int r = 4; r < 8; r++) begin issue_ld(r, 2, 0, 0); cycle(); end
    issue_ld(8, 2, 0, 0); cycle();
    check("full_ld_ready", {31'b0, obs_lr}, 32'd0);
    issue_ld(4, 2, 0, 0); mem_rvalid = 1'b1; mem_rdata = 32'h4; cycle();
    check("busy_ld_ready", {31'b0, obs_lr}, 32'd0);
    issue_ld(5, 2, 0, 0); cycle();
    check("busy5_ld_ready", {31'b0, obs_lr}, 32'd0);
    issue_ld(8, 2, 0, 0); cycle();
    issue_ld(9, 2, 0, 0); mem_rvalid = 1'b1; mem_rdata = 32'h5; cycle();
    check("pushpop_full_ready", {31'b0, obs_lr}, 32'd1);
    check("pushpop_count", m_lq.size(), 32'd4);
    for (int i = 0; i < 4; i++) begin idle(); mem_rvalid = 1'b1; mem_rdata = $urandom; cycle(); end

    // spurious response, rd0 ALU write
    idle(); mem_rvalid = 1'b1; cycle();
    check("spur_err", {31'b0, err}, 32'd1);
    check("spur_we", {31'b0, rf_we}, 32'd0);
    idle(); alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'hDEAD; cycle();
    check("rd0_ready", {31'b0, obs_ar}, 32'd1);
    check("rd0_we", {31'b0, rf_we}, 32'd0);

    // reset mid-stream
    issue_ld(10, 0, 1, 1); cycle();
    idle(); rst = 1'b1; cycle();
    check("rst_busy", busy, 32'h0);
    check("rst_err", {31'b0, err}, 32'd0);

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      idle();
      rst         = ($urandom_range(0, 99) == 0);
      alu_valid   = $urandom_range(0, 1);
      alu_rd      = 5'($urandom_range(0, 7));
      alu_data    = $urandom;
      ld_valid    = $urandom_range(0, 1);
      ld_rd       = 5'($urandom_range(0, 9));
      ld_size     = 2'($urandom_range(0, 3));
      ld_unsigned = $urandom_range(0, 1);
      ld_offset   = 2'($urandom_range(0, 3));
      mem_rvalid  = (m_lq.size() > 0 && $urandom_range(0, 1) == 1) || ($urandom_range(0, 59) == 0);
      mem_rdata   = $urandom;
      cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
